// File: rtl/lbp_pkg.sv
// Shared constants, state encoding and border test for the LBP host and engine.
`timescale 1ns/1ps
package lbp_pkg;

  localparam int unsigned IMG_W           = 128;
  localparam int unsigned IMG_H           = 128;
  localparam int unsigned AW              = 14;
  localparam int unsigned DW              = 8;
  localparam int unsigned NUM_PIXELS      = IMG_W * IMG_H;
  localparam int unsigned INTERIOR_PIXELS = (IMG_W - 2) * (IMG_H - 2);

  typedef enum logic [1:0] {
    StLoad,
    StServe,
    StDone
  } state_e;

  // Power-of-two widths reduce the modulo/divide to bit selects in synthesis.
  function automatic logic is_border(input logic [AW-1:0] addr);
    int unsigned row;
    int unsigned col;
    col = 32'(addr) % IMG_W;
    row = 32'(addr) / IMG_W;
    return (row == 0) || (row == IMG_H - 1) || (col == 0) || (col == IMG_W - 1);
  endfunction

endpackage

// File: rtl/lbp_host_mem_if.sv
// Loader, engine and read-out signals of the LBP host memory.
`timescale 1ns/1ps
interface lbp_host_mem_if;
  import lbp_pkg::*;

  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          load_done;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [DW-1:0] gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [DW-1:0] lbp_data;
  logic          finish;
  logic          done;
  logic [AW-1:0] wr_count;
  logic          border_err;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  modport slave (
    input  ld_valid, ld_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish,
           rd_req, rd_addr,
    output load_done, gray_ready, gray_data, done, wr_count, border_err, rd_data
  );

  modport master (
    output ld_valid, ld_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish,
           rd_req, rd_addr,
    input  load_done, gray_ready, gray_data, done, wr_count, border_err, rd_data
  );

endinterface

// File: rtl/lbp_sp_ram.sv
// Single-port synchronous RAM; the read register holds when no read is issued.
`timescale 1ns/1ps
module lbp_sp_ram #(
  parameter int unsigned Depth = 16384,
  parameter int unsigned AddrW = 14,
  parameter int unsigned DataW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic [DataW-1:0] wdata,
  output logic [DataW-1:0] rdata
);

  logic [DataW-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/lbp_host_mem.sv
// Host-side gray image and LBP result buffers with load / serve / read-out sequencing.
`timescale 1ns/1ps
module lbp_host_mem
  import lbp_pkg::*;
(
  input logic           clk,
  input logic           reset,
  lbp_host_mem_if.slave bus
);

  state_e        state_q, state_d;
  logic [AW-1:0] ld_cnt_q, ld_cnt_d;
  logic [AW-1:0] wr_count_q;
  logic          border_err_q;
  logic          rd_border_q;

  logic          in_load, in_serve, in_done;
  logic          ld_fire, ld_last, wr_fire, wr_border, rd_fire;
  logic          gray_en, res_en;
  logic [AW-1:0] gray_addr_mux, res_addr_mux;
  logic [DW-1:0] res_rdata;

  assign in_load   = (state_q == StLoad);
  assign in_serve  = (state_q == StServe);
  assign in_done   = (state_q == StDone);
  assign ld_fire   = in_load && bus.ld_valid;
  assign ld_last   = (ld_cnt_q == AW'(NUM_PIXELS - 1));
  assign wr_fire   = in_serve && bus.lbp_valid;
  assign wr_border = is_border(bus.lbp_addr);
  assign rd_fire   = in_done && bus.rd_req;

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    unique case (state_q)
      StLoad: begin
        if (ld_fire) begin
          ld_cnt_d = ld_last ? '0 : ld_cnt_q + 1'b1;
          if (ld_last) state_d = StServe;
        end
      end
      StServe: if (bus.finish) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StLoad;
      ld_cnt_q     <= '0;
      wr_count_q   <= '0;
      border_err_q <= 1'b0;
      rd_border_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      if (wr_fire) begin
        if (wr_count_q != '1) wr_count_q <= wr_count_q + 1'b1;
        if (wr_border) border_err_q <= 1'b1;
      end
      if (rd_fire) rd_border_q <= is_border(bus.rd_addr);
    end
  end

  // Gray RAM port: loader writes in LOAD, engine reads in SERVE.
  assign gray_en       = ld_fire || (in_serve && bus.gray_req);
  assign gray_addr_mux = ld_fire ? ld_cnt_q : bus.gray_addr;

  lbp_sp_ram #(.Depth(NUM_PIXELS), .AddrW(AW), .DataW(DW)) u_gray_ram (
    .clk   (clk),
    .reset (reset),
    .en    (gray_en),
    .we    (ld_fire),
    .addr  (gray_addr_mux),
    .wdata (bus.ld_data),
    .rdata (bus.gray_data)
  );

  // Result RAM port: engine writes in SERVE (border writes dropped), read-out in DONE.
  assign res_en       = (wr_fire && !wr_border) || rd_fire;
  assign res_addr_mux = in_serve ? bus.lbp_addr : bus.rd_addr;

  lbp_sp_ram #(.Depth(NUM_PIXELS), .AddrW(AW), .DataW(DW)) u_res_ram (
    .clk   (clk),
    .reset (reset),
    .en    (res_en),
    .we    (in_serve),
    .addr  (res_addr_mux),
    .wdata (bus.lbp_data),
    .rdata (res_rdata)
  );

  assign bus.rd_data    = rd_border_q ? '0 : res_rdata;
  assign bus.load_done  = !in_load;
  assign bus.gray_ready = in_serve;
  assign bus.done       = in_done;
  assign bus.wr_count   = wr_count_q;
  assign bus.border_err = border_err_q;

endmodule

// File: tb/tb_lbp_host_mem.sv
// Directed and randomized checks of lbp_host_mem against an array-based image model.
`timescale 1ns/1ps
module tb_lbp_host_mem;
  import lbp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lbp_host_mem_if bus ();
  lbp_host_mem dut (.clk(clk), .reset(reset), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] img [NUM_PIXELS];
  logic [7:0] res [NUM_PIXELS];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit tb_border(input int a);
    int row = a / 128;
    int col = a % 128;
    return row == 0 || row == 127 || col == 0 || col == 127;
  endfunction

  function automatic logic [7:0] lbp_of(input int a);
    int offs [8] = '{-129, -128, -127, 1, 129, 128, 127, -1};
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = (img[a + offs[k]] >= img[a]);
    return r;
  endfunction

  function automatic int rand_interior();
    return $urandom_range(1, 126) * 128 + $urandom_range(1, 126);
  endfunction

  task automatic idle();
    bus.ld_valid = 0; bus.ld_data = '0; bus.gray_req = 0; bus.gray_addr = '0;
    bus.lbp_valid = 0; bus.lbp_addr = '0; bus.lbp_data = '0; bus.finish = 0;
    bus.rd_req = 0; bus.rd_addr = '0;
  endtask

  task automatic check_reset_state();
    chk("rst_load_done", bus.load_done, 0);
    chk("rst_gray_ready", bus.gray_ready, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_border_err", bus.border_err, 0);
    chk("rst_wr_count", bus.wr_count, 0);
    chk("rst_gray_data", bus.gray_data, 0);
    chk("rst_rd_data", bus.rd_data, 0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
    check_reset_state();
  endtask

  // Engine strobes are thrown at the block during load; all must be ignored.
  task automatic load_image(input bit rnd);
    int i = 0;
    while (i < NUM_PIXELS) begin
      logic [7:0] v;
      bus.gray_req  = 1'($urandom);
      bus.gray_addr = AW'($urandom);
      bus.lbp_valid = 1'($urandom);
      bus.lbp_addr  = AW'(rand_interior());
      bus.lbp_data  = 8'($urandom);
      bus.finish    = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) begin
        bus.ld_valid = 0;
        bus.ld_data  = 8'($urandom);
        tick();
      end else begin
        v = rnd ? 8'($urandom) : 8'(i);
        img[i] = v;
        bus.ld_valid = 1;
        bus.ld_data  = v;
        tick();
        i++;
        if (i == NUM_PIXELS - 1) chk("gray_ready_before_last", bus.gray_ready, 0);
      end
    end
    idle();
    chk("load_done", bus.load_done, 1);
    chk("gray_ready_after_load", bus.gray_ready, 1);
    chk("done_after_load", bus.done, 0);
    chk("wr_count_after_load", bus.wr_count, 0);
    chk("gray_data_after_load", bus.gray_data, 0);
  endtask

  initial begin
    int addrs [3] = '{0, 129, 258};
    int btab [10] = '{0, 127, 128, 255, 16256, 16383, 129, 254, 16129, 16254};
    int a;
    int ga;
    bit greq;
    logic [7:0] gexp;

    // ---- Directed: ramp image, first reads, interior and border writes ----
    do_reset();
    load_image(0);
    bus.gray_req = 1; bus.gray_addr = 300;
    tick();
    chk("read_300", bus.gray_data, 8'h2C);
    bus.gray_req = 0; bus.gray_addr = 5;
    tick();
    chk("read_hold", bus.gray_data, 8'h2C);
    bus.gray_req = 1;
    foreach (addrs[k]) begin
      bus.gray_addr = AW'(addrs[k]);
      tick();
      chk("b2b_read", bus.gray_data, 32'(addrs[k] % 256));
    end
    bus.gray_req = 0;
    bus.rd_req = 1; bus.rd_addr = 129;
    tick();
    chk("rd_ignored_in_serve", bus.rd_data, 0);
    bus.rd_req = 0;
    bus.lbp_valid = 1; bus.lbp_addr = 129; bus.lbp_data = 8'hA5;
    tick();
    chk("wr_count_1", bus.wr_count, 1);
    chk("border_err_clear", bus.border_err, 0);
    bus.lbp_addr = 127; bus.lbp_data = 8'hFF;
    tick();
    chk("border_err_set", bus.border_err, 1);
    chk("wr_count_border", bus.wr_count, 2);
    bus.lbp_addr = 130; bus.lbp_data = 8'h3C; bus.finish = 1;
    tick();
    bus.finish = 0;
    chk("done_set", bus.done, 1);
    chk("gray_ready_clear", bus.gray_ready, 0);
    chk("wr_with_finish", bus.wr_count, 3);
    bus.lbp_addr = 129; bus.lbp_data = 8'h00; bus.gray_req = 1; bus.gray_addr = 0;
    bus.ld_valid = 1;
    tick();
    idle();
    chk("wr_ignored_in_done", bus.wr_count, 3);
    chk("gray_ignored_in_done", bus.gray_data, 8'h02);
    bus.rd_req = 1; bus.rd_addr = 129;
    tick();
    chk("readout_129", bus.rd_data, 8'hA5);
    bus.rd_addr = 127;
    tick();
    chk("readout_border_127", bus.rd_data, 0);
    bus.rd_addr = 130;
    tick();
    chk("readout_130", bus.rd_data, 8'h3C);
    bus.rd_req = 0;
    tick();
    chk("readout_hold", bus.rd_data, 8'h3C);
    chk("border_err_sticky", bus.border_err, 1);

    // ---- Reset mid-SERVE after 5000 writes ----
    do_reset();
    load_image(1);
    bus.lbp_valid = 1;
    for (int n = 0; n < 5000; n++) begin
      bus.lbp_addr = AW'(rand_interior());
      bus.lbp_data = 8'($urandom);
      tick();
    end
    bus.lbp_addr = 128;
    chk("wr_count_5000", bus.wr_count, 5000);
    tick();
    chk("border_col0", bus.border_err, 1);
    chk("wr_count_5001", bus.wr_count, 5001);
    do_reset();

    // ---- Full run: random image, LBP writes for every interior pixel, random reads ----
    load_image(1);
    gexp = 8'h00;
    for (int r = 1; r < 127; r++) begin
      for (int c = 1; c < 127; c++) begin
        a = r * 128 + c;
        res[a] = lbp_of(a);
        bus.lbp_valid = 1; bus.lbp_addr = AW'(a); bus.lbp_data = res[a];
        greq = 1'($urandom);
        ga = $urandom_range(0, NUM_PIXELS - 1);
        bus.gray_req = greq; bus.gray_addr = AW'(ga);
        tick();
        if (greq) gexp = img[ga];
        chk("serve_read", bus.gray_data, gexp);
      end
    end
    idle();
    chk("wr_count_full", bus.wr_count, INTERIOR_PIXELS);
    chk("border_err_full", bus.border_err, 0);
    chk("done_before_finish", bus.done, 0);
    bus.finish = 1;
    tick();
    bus.finish = 0;
    chk("done_full", bus.done, 1);
    bus.rd_req = 1;
    for (int n = 0; n < 500; n++) begin
      a = (n < 10) ? btab[n] : $urandom_range(0, NUM_PIXELS - 1);
      bus.rd_addr = AW'(a);
      tick();
      chk("readout_full", bus.rd_data, tb_border(a) ? 32'd0 : 32'(res[a]));
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
